fifo_flush_async_param: RTL
===========================

Name: fifo_flush_async_param

Overview:
Parametrised dual-clock FIFO with burst-flush readout. The write side runs on wclock and the read side on rclock. Pointers cross domains as Gray code through multi-stage synchronizers. On the read side, a single-word pop or a multi-word flush packs up to FLUSH_WORDS entries into a wide output, padded with PAD. It sits between a narrow producer and a consumer that drains in bursts.

Parameters:
DW, 4, data word width in bits
DEPTH, 32, entries; power of two, >= 4
FLUSH_WORDS, 8, max words per flush, 1..DEPTH
PAD, 4'hC (DW bits), filler for unused flush slots
SYNC_STAGES, 2, synchronizer flops per crossing, >= 2

Ports:
wclock  in  1  write clock
reset  in  1  asynchronous, active-low; clock wclock; also asynchronously resets the rclock domain
rclock  in  1  read clock
wr_valid_i  in  1  write request
wr_data_i  in  DW  write data
wr_ready_o  out  1  high when not full
full_o  out  1  FIFO full (wclock domain)
overflow_o  out  1  sticky: a write was attempted while full
wr_level_o  out  AW+1  occupancy seen by writer (AW = log2 DEPTH)
rd_valid_i  in  1  pop request
rd_data_o  out  DW  popped word
rd_data_valid_o  out  1  one-cycle pulse, rd_data_o valid
flush_i  in  1  flush request
flush_data_o  out  FLUSH_WORDS*DW  packed flush words; slot k at bits [k*DW +: DW]
flush_count_o  out  log2(FLUSH_WORDS)+1  words delivered by the flush
flush_valid_o  out  1  one-cycle pulse
empty_o  out  1  FIFO empty (rclock domain)
rd_level_o  out  AW+1  occupancy seen by reader

Behaviour:
- Reset (reset=0): both pointers 0; empty_o=1; full_o=0; wr_ready_o=1; overflow_o=0; levels 0; all data outputs 0; all valid pulses 0. Memory contents need not be cleared. Reset mid-operation aborts any flush or pop; no pulse is emitted.
- Pointers are AW+1 bits binary, with registered Gray copies. The Gray copy crosses through SYNC_STAGES flops into the other domain.
- full_o = (wr_gray == rd_gray_sync with its two MSBs inverted). empty_o = (rd_gray == wr_gray_sync). Both are registered from next-pointer values, so they are exact in their own domain.
- Levels = own binary pointer minus the converted synced pointer, modulo 2^(AW+1). Levels are pessimistic by up to SYNC_STAGES+1 cycles of the other clock.
- Write: wr_valid_i && !full_o -> mem[wr_ptr] = wr_data_i; wr_ptr+1. Write while full is dropped, sets overflow_o, and leaves the pointer unchanged.
- Pop: rd_valid_i && !flush_i && !empty_o -> at the next rclock edge, rd_data_o = mem[rd_ptr], rd_data_valid_o=1, rd_ptr+1. Latency is 1 cycle. Pop while empty is ignored; rd_data_o holds its value and no pulse is emitted.
- Flush: flush_i at an rclock edge. n = min(FLUSH_WORDS, rd_level). Next cycle:
  - slot k = mem[rd_ptr+k] for k<n, otherwise PAD;
  - flush_count_o=n; flush_valid_o=1; rd_ptr += n.
  - Flush on empty: n=0, all slots PAD, pulse still asserted.
- flush_data_o and flush_count_o hold until the next flush.
- Flush has priority over pop in the same cycle. The pop is discarded and rd_data_valid_o=0.
- Pointer and address indexing wraps modulo DEPTH. Flush slots that cross the array end wrap correctly.
- Back-to-back flushes are legal every cycle.
- Concurrent write and read at full/empty boundaries are safe. The writer may still see full_o for up to SYNC_STAGES+1 wclock cycles after a pop.

Decomposition:
- Package fifo_flush_pkg holds:
  - bin2gray and gray2bin functions;
  - a clog2-based width helper;
  - the default PAD constant.
- One sub-module, fifo_ptr_sync: a parametrised SYNC_STAGES-deep Gray-pointer synchronizer with asynchronous active-low reset. It is instantiated twice.
- Memory, flush packer, and flag logic stay in the top module.

Test Plan:
All scenarios use DW=4, DEPTH=32, FLUSH_WORDS=8, PAD=C, SYNC_STAGES=2, wclock 10 ns, rclock 13 ns.
1. Write 1,2,3, wait 4 rclocks, flush -> flush_data_o=0xCCCCC321, flush_count_o=3, then empty_o=1.
2. Write 0..F,0..3 (20 words), flush -> data 0x76543210, count 8, rd_level_o=12; then pop -> rd_data_o=8 with a 1-cycle pulse.
3. Write 32 words -> full_o=1, wr_ready_o=0. A 33rd write is dropped and overflow_o=1. Pop one -> full_o clears within 3 wclocks.
4. Flush and pop asserted in the same cycle with 5 words queued -> flush_valid_o=1, count 5, rd_data_valid_o=0, empty_o=1.
5. Pop on empty -> no pulse, rd_data_o unchanged. Flush on empty -> count 0, data 0xCCCCCCCC. Wrap case: with rd_ptr=28 and 6 words queued, flush returns entries 28..31,0,1 in order.
6. Assert reset mid-flush burst -> all outputs at reset values. empty_o=1, full_o=0, overflow_o=0. Normal traffic resumes after release.

Source files
------------

// File: rtl/fifo_flush_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------+
// | fifo_flush_pkg: Gray-code helpers and defaults for fifo_flush_async |
// | Revision: 1.0                                                       |
// +--------------------------------------------------------------------+
package fifo_flush_pkg;

  localparam int         PTR_MAX     = 32;
  localparam logic [3:0] PAD_DEFAULT = 4'hC;

  function automatic int width_of(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  function automatic logic [PTR_MAX-1:0] bin2gray(input logic [PTR_MAX-1:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [PTR_MAX-1:0] gray2bin(input logic [PTR_MAX-1:0] g);
    logic [PTR_MAX-1:0] b;
    b[PTR_MAX-1] = g[PTR_MAX-1];
    for (int i = PTR_MAX - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fifo_ptr_sync.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------+
// | fifo_ptr_sync: STAGES-deep flop chain for a Gray-coded pointer      |
// | Revision: 1.0                                                       |
// +--------------------------------------------------------------------+
module fifo_ptr_sync
  import fifo_flush_pkg::*;
#(
  parameter int W      = 6,
  parameter int STAGES = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);

  logic [W-1:0] r_sync [STAGES];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < STAGES; i++) r_sync[i] <= '0;
    end else begin
      r_sync[0] <= i_d;
      for (int i = 1; i < STAGES; i++) r_sync[i] <= r_sync[i-1];
    end
  end

  assign o_q = r_sync[STAGES-1];

endmodule
`default_nettype wire

// File: rtl/fifo_flush_async_param.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------+
// | fifo_flush_async_param: dual-clock FIFO with pop and burst flush    |
// | Revision: 1.0                                                       |
// +--------------------------------------------------------------------+
module fifo_flush_async_param
  import fifo_flush_pkg::*;
#(
  parameter int            DW          = 4,
  parameter int            DEPTH       = 32,
  parameter int            FLUSH_WORDS = 8,
  parameter logic [DW-1:0] PAD         = DW'(PAD_DEFAULT),
  parameter int            SYNC_STAGES = 2,
  localparam int           AW          = width_of(DEPTH),
  localparam int           PW          = AW + 1,
  localparam int           CW          = $clog2(FLUSH_WORDS) + 1
) (
  input  logic                      wclock,
  input  logic                      reset,
  input  logic                      rclock,
  input  logic                      wr_valid_i,
  input  logic [DW-1:0]             wr_data_i,
  output logic                      wr_ready_o,
  output logic                      full_o,
  output logic                      overflow_o,
  output logic [AW:0]               wr_level_o,
  input  logic                      rd_valid_i,
  output logic [DW-1:0]             rd_data_o,
  output logic                      rd_data_valid_o,
  input  logic                      flush_i,
  output logic [FLUSH_WORDS*DW-1:0] flush_data_o,
  output logic [CW-1:0]             flush_count_o,
  output logic                      flush_valid_o,
  output logic                      empty_o,
  output logic [AW:0]               rd_level_o
);

  logic [DW-1:0] r_mem [DEPTH];

  logic [PW-1:0] r_wr_ptr, r_wr_gray, r_rd_ptr, r_rd_gray;
  logic [PW-1:0] w_rd_gray_sync, w_wr_gray_sync;
  logic          r_full, r_overflow, r_empty;

  // ---------------- write domain ----------------
  logic          w_wr_en, w_full_nxt;
  logic [PW-1:0] w_wr_ptr_nxt, w_wr_gray_nxt, w_rd_ptr_sync_bin;

  assign w_wr_en           = wr_valid_i & ~r_full;
  assign w_wr_ptr_nxt      = r_wr_ptr + PW'(w_wr_en);
  assign w_wr_gray_nxt     = PW'(bin2gray(PTR_MAX'(w_wr_ptr_nxt)));
  assign w_full_nxt        = (w_wr_gray_nxt ==
                              {~w_rd_gray_sync[AW:AW-1], w_rd_gray_sync[AW-2:0]});
  assign w_rd_ptr_sync_bin = PW'(gray2bin(PTR_MAX'(w_rd_gray_sync)));

  always_ff @(posedge wclock or negedge reset) begin
    if (!reset) begin
      r_wr_ptr   <= '0;
      r_wr_gray  <= '0;
      r_full     <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      r_wr_ptr  <= w_wr_ptr_nxt;
      r_wr_gray <= w_wr_gray_nxt;
      r_full    <= w_full_nxt;
      if (wr_valid_i && r_full) r_overflow <= 1'b1;
    end
  end

  always_ff @(posedge wclock) begin
    if (w_wr_en) r_mem[r_wr_ptr[AW-1:0]] <= wr_data_i;
  end

  fifo_ptr_sync #(.W(PW), .STAGES(SYNC_STAGES)) u_rd2wr (
    .clk(wclock), .reset(reset), .i_d(r_rd_gray), .o_q(w_rd_gray_sync)
  );
  fifo_ptr_sync #(.W(PW), .STAGES(SYNC_STAGES)) u_wr2rd (
    .clk(rclock), .reset(reset), .i_d(r_wr_gray), .o_q(w_wr_gray_sync)
  );

  // ---------------- read domain ----------------
  logic                      w_pop, w_empty_nxt;
  logic [PW-1:0]             w_wr_ptr_sync_bin, w_rd_level, w_flush_n;
  logic [PW-1:0]             w_rd_ptr_nxt, w_rd_gray_nxt;
  logic [FLUSH_WORDS*DW-1:0] w_flush_pack;

  assign w_wr_ptr_sync_bin = PW'(gray2bin(PTR_MAX'(w_wr_gray_sync)));
  assign w_rd_level        = w_wr_ptr_sync_bin - r_rd_ptr;
  assign w_flush_n         = (w_rd_level > PW'(FLUSH_WORDS)) ? PW'(FLUSH_WORDS) : w_rd_level;
  assign w_pop             = rd_valid_i & ~flush_i & ~r_empty;
  assign w_rd_ptr_nxt      = flush_i ? (r_rd_ptr + w_flush_n) : (r_rd_ptr + PW'(w_pop));
  assign w_rd_gray_nxt     = PW'(bin2gray(PTR_MAX'(w_rd_ptr_nxt)));
  assign w_empty_nxt       = (w_rd_gray_nxt == w_wr_gray_sync);

  // Slot addresses use AW-bit arithmetic so bursts spanning the array end wrap.
  for (genvar k = 0; k < FLUSH_WORDS; k++) begin : g_slot
    logic [AW-1:0] w_addr;
    assign w_addr = r_rd_ptr[AW-1:0] + AW'(k);
    assign w_flush_pack[k*DW +: DW] = (PW'(k) < w_flush_n) ? r_mem[w_addr] : PAD;
  end

  logic [DW-1:0]             r_rd_data;
  logic                      r_rd_valid, r_flush_valid;
  logic [FLUSH_WORDS*DW-1:0] r_flush_data;
  logic [CW-1:0]             r_flush_count;

  always_ff @(posedge rclock or negedge reset) begin
    if (!reset) begin
      r_rd_ptr      <= '0;
      r_rd_gray     <= '0;
      r_empty       <= 1'b1;
      r_rd_data     <= '0;
      r_rd_valid    <= 1'b0;
      r_flush_valid <= 1'b0;
      r_flush_data  <= '0;
      r_flush_count <= '0;
    end else begin
      r_rd_ptr      <= w_rd_ptr_nxt;
      r_rd_gray     <= w_rd_gray_nxt;
      r_empty       <= w_empty_nxt;
      r_rd_valid    <= w_pop;
      r_flush_valid <= flush_i;
      if (w_pop) r_rd_data <= r_mem[r_rd_ptr[AW-1:0]];
      if (flush_i) begin
        r_flush_data  <= w_flush_pack;
        r_flush_count <= CW'(w_flush_n);
      end
    end
  end

  assign wr_ready_o      = ~r_full;
  assign full_o          = r_full;
  assign overflow_o      = r_overflow;
  assign wr_level_o      = r_wr_ptr - w_rd_ptr_sync_bin;
  assign rd_data_o       = r_rd_data;
  assign rd_data_valid_o = r_rd_valid;
  assign flush_data_o    = r_flush_data;
  assign flush_count_o   = r_flush_count;
  assign flush_valid_o   = r_flush_valid;
  assign empty_o         = r_empty;
  assign rd_level_o      = w_rd_level;

endmodule
`default_nettype wire
